// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and helpers for the multi-slave SPI master
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    HOLD,
    TRAIL
  } state_t;

  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SPI clock divider with leading/trailing edge strobes
module spi_clk_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic i_sclk,
  input  logic i_reset,
  input  logic enable,
  input  logic cpol,
  output logic lead_stb,
  output logic trail_stb,
  output logic last_edge,
  output logic spi_clk
);

  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EC_W = $clog2(2 * DATA_W);

  logic [HC_W-1:0] half_cnt;
  logic [EC_W-1:0] edge_cnt;
  logic            phase;
  logic            half_done;

  assign half_done = enable && (half_cnt == HC_W'(CLK_DIV - 1));
  assign lead_stb  = half_done && !edge_cnt[0];
  assign trail_stb = half_done && edge_cnt[0];
  assign last_edge = trail_stb && (edge_cnt == EC_W'(2 * DATA_W - 1));

  // Level derives from cpol combinationally so a new polarity shows the cycle it is latched
  assign spi_clk = cpol ^ phase;

  always_ff @(posedge i_sclk or negedge i_reset) begin
    if (!i_reset) begin
      half_cnt <= '0;
      edge_cnt <= '0;
      phase    <= 1'b0;
    end else if (!enable || last_edge) begin
      half_cnt <= '0;
      edge_cnt <= '0;
      phase    <= 1'b0;
    end else if (half_done) begin
      half_cnt <= '0;
      edge_cnt <= edge_cnt + 1'b1;
      phase    <= ~phase;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - full-duplex SPI master, all four modes, burst hold, NUM_CS selects
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_CS    = 1,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                                  i_sclk,
  input  logic                                  i_reset,
  input  logic                                  i_tx_valid,
  output logic                                  o_tx_ready,
  input  logic [DATA_W-1:0]                     i_tx_data,
  input  logic [spi_pkg::cs_width(NUM_CS)-1:0]  i_cs_sel,
  input  logic                                  i_cpol,
  input  logic                                  i_cpha,
  input  logic                                  i_hold,
  output logic                                  o_rx_valid,
  output logic [DATA_W-1:0]                     o_rx_data,
  output logic                                  o_busy,
  output logic                                  o_spi_clk,
  output logic                                  o_mosi,
  input  logic                                  i_miso,
  output logic [NUM_CS-1:0]                     o_ss_n
);

  localparam int CS_W = cs_width(NUM_CS);
  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   cnt_q;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_data_q;
  logic [CS_W-1:0]   sel_q;
  logic              cpol_q, cpha_q, hold_q, mosi_q, rx_valid_q;
  logic              accept, shift_evt, sample_evt;
  logic              lead_stb, trail_stb, last_edge;

  function automatic logic first_bit(input logic [DATA_W-1:0] d);
    return (MSB_FIRST != 0) ? d[DATA_W-1] : d[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d);
    return (MSB_FIRST != 0) ? {d[DATA_W-2:0], 1'b0} : {1'b0, d[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sr, input logic b);
    return (MSB_FIRST != 0) ? {sr[DATA_W-2:0], b} : {b, sr[DATA_W-1:1]};
  endfunction

  spi_clk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_sclk    (i_sclk),
    .i_reset   (i_reset),
    .enable    (state_q == XFER),
    .cpol      (cpol_q),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .last_edge (last_edge),
    .spi_clk   (o_spi_clk)
  );

  // In HOLD only a word for the same slave may continue the burst
  assign o_tx_ready = i_reset && ((state_q == IDLE) || ((state_q == HOLD) && (i_cs_sel == sel_q)));
  assign accept     = i_tx_valid && o_tx_ready;
  assign shift_evt  = cpha_q ? lead_stb : (trail_stb && !last_edge);
  assign sample_evt = cpha_q ? trail_stb : lead_stb;

  assign o_busy     = (state_q != IDLE);
  assign o_mosi     = mosi_q;
  assign o_rx_valid = rx_valid_q;
  assign o_rx_data  = rx_data_q;

  always_ff @(posedge i_sclk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if ((state_q == LEAD) || (state_q == TRAIL))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    o_ss_n  = '1;
    case (state_q)
      IDLE:  if (accept) state_d = LEAD;
      LEAD:  if (cnt_q == HC_W'(CLK_DIV - 1)) state_d = XFER;
      XFER:  if (last_edge) state_d = hold_q ? HOLD : TRAIL;
      HOLD: begin
        if (accept)
          state_d = XFER;
        else if (!i_hold || (i_tx_valid && (i_cs_sel != sel_q)))
          state_d = TRAIL;
      end
      TRAIL: if (cnt_q == HC_W'(CLK_DIV - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An out-of-range select matches no line, so the word runs with all selects high
    if (state_q != IDLE) begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (sel_q == CS_W'(i)) o_ss_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_sclk or negedge i_reset) begin
    if (!i_reset) begin
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data_q  <= '0;
      sel_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      hold_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (accept) begin
        sel_q  <= i_cs_sel;
        cpol_q <= i_cpol;
        cpha_q <= i_cpha;
        hold_q <= i_hold;
        // cpha=0 presents the first bit before the first edge; cpha=1 waits for the leading edge
        if (i_cpha) begin
          tx_sr  <= i_tx_data;
          mosi_q <= 1'b0;
        end else begin
          tx_sr  <= shift_out(i_tx_data);
          mosi_q <= first_bit(i_tx_data);
        end
      end else if (state_q == XFER) begin
        if (shift_evt) begin
          mosi_q <= first_bit(tx_sr);
          tx_sr  <= shift_out(tx_sr);
        end
        if (sample_evt)
          rx_sr <= shift_in(rx_sr, i_miso);
        if (last_edge) begin
          rx_valid_q <= 1'b1;
          rx_data_q  <= cpha_q ? shift_in(rx_sr, i_miso) : rx_sr;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - scoreboard bench for spi_master_multi (8-bit/4-CS and 16-bit LSB-first)
module tb_spi_master_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [15:0] tdata = '0;
  logic [1:0]  sel = '0;
  logic        cpol = 1'b0, cpha = 1'b0, hold = 1'b0;

  logic        rdy1, rxv1, busy1, sck1, mosi1, miso1;
  logic [7:0]  rxd1;
  logic [3:0]  ssn1;
  logic        rdy2, rxv2, busy2, sck2, mosi2;
  logic [15:0] rxd2;
  logic [0:0]  ssn2;

  logic        loopback = 1'b1;
  logic        slave_bit = 1'b0;
  logic [7:0]  slave_word = '0;
  logic        m_cpol = 1'b0, m_cpha = 1'b0;
  logic        burst_chk = 1'b0;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int edges1 = 0, lead1 = 0, lead_base = 0, viol1 = 0, rx_cnt1 = 0, rx_cyc1 = 0, last_low1 = 0;
  int rx_cyc2 = 0;
  logic [7:0]  cap1 = '0;
  logic [15:0] cap2 = '0;
  logic        prev_sck1 = 1'b0, prev_act1 = 1'b0, prev_sck2 = 1'b0, prev_act2 = 1'b0;

  logic [7:0]  exp_q1[$];
  logic [15:0] exp_q2[$];

  assign miso1 = loopback ? mosi1 : slave_bit;

  spi_master_multi #(.DATA_W(8), .NUM_CS(4), .CLK_DIV(2), .MSB_FIRST(1)) dut1 (
    .i_sclk(clk), .i_reset(rst_n), .i_tx_valid(v1), .o_tx_ready(rdy1),
    .i_tx_data(tdata[7:0]), .i_cs_sel(sel), .i_cpol(cpol), .i_cpha(cpha), .i_hold(hold),
    .o_rx_valid(rxv1), .o_rx_data(rxd1), .o_busy(busy1), .o_spi_clk(sck1),
    .o_mosi(mosi1), .i_miso(miso1), .o_ss_n(ssn1)
  );

  spi_master_multi #(.DATA_W(16), .NUM_CS(1), .CLK_DIV(1), .MSB_FIRST(0)) dut2 (
    .i_sclk(clk), .i_reset(rst_n), .i_tx_valid(v2), .o_tx_ready(rdy2),
    .i_tx_data(tdata), .i_cs_sel(sel[0]), .i_cpol(cpol), .i_cpha(cpha), .i_hold(hold),
    .o_rx_valid(rxv2), .o_rx_data(rxd2), .o_busy(busy2), .o_spi_clk(sck2),
    .o_mosi(mosi2), .i_miso(mosi2), .o_ss_n(ssn2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // DUT1 monitor: edge counting, MOSI capture at sample edges, mode-3 slave, scoreboard
  always @(negedge clk) begin
    logic act;
    int   k;
    act = (ssn1 != 4'hF);
    if (act && prev_act1 && (sck1 !== prev_sck1)) begin
      edges1++;
      if (sck1 != m_cpol) begin
        if (!m_cpha) cap1 = {cap1[6:0], mosi1};
        k = lead1 - lead_base;
        if (k < 8) slave_bit = slave_word[7-k];
        lead1++;
      end else if (m_cpha) begin
        cap1 = {cap1[6:0], mosi1};
      end
    end
    if (act) last_low1 = cyc;
    if (burst_chk && busy1 && (ssn1 !== 4'b1011)) viol1++;
    prev_sck1 = sck1;
    prev_act1 = act;
    if (rxv1) begin
      rx_cnt1++;
      rx_cyc1 = cyc;
      if (exp_q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx1 unexpected pulse: got %0h, expected no pulse", rxd1);
      end else begin
        chk("rx1 data", 32'(rxd1), 32'(exp_q1.pop_front()));
      end
    end
  end

  // DUT2 monitor: LSB-first MOSI capture on rising edges, scoreboard
  always @(negedge clk) begin
    logic act;
    act = (ssn2 == 1'b0);
    if (act && prev_act2 && !prev_sck2 && sck2) cap2 = {mosi2, cap2[15:1]};
    prev_sck2 = sck2;
    prev_act2 = act;
    if (rxv2) begin
      rx_cyc2 = cyc;
      if (exp_q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx2 unexpected pulse: got %0h, expected no pulse", rxd2);
      end else begin
        chk("rx2 data", 32'(rxd2), 32'(exp_q2.pop_front()));
      end
    end
  end

  task automatic send(input int which, input logic [15:0] d, input logic [15:0] expd, input bit push,
                      input logic [1:0] s, input logic pol, input logic pha, input logic hd,
                      output int acc);
    bit ok;
    ok  = 1'b0;
    acc = 0;
    if (push) begin
      if (which == 0) exp_q1.push_back(expd[7:0]);
      else            exp_q2.push_back(expd);
    end
    @(negedge clk);
    tdata = d; sel = s; cpol = pol; cpha = pha; hold = hd;
    m_cpol = pol; m_cpha = pha;
    if (which == 0) v1 = 1'b1; else v2 = 1'b1;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (((which == 0) ? rdy1 : rdy2) == 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("tx accepted", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    v1 = 1'b0;
    v2 = 1'b0;
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic wait_idle(input int which, output int idle_cyc);
    bit done;
    done = 1'b0;
    idle_cyc = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (((which == 0) ? busy1 : busy2) == 1'b0) begin
        done = 1'b1;
        idle_cyc = cyc;
      end
    end
    chk("idle reached", 32'(done), 32'd1);
  endtask

  initial begin
    int acc, acc2, ic, eb, vb, rb;

    repeat (3) @(negedge clk);
    #1;
    chk("reset ss_n", 32'(ssn1), 32'hF);
    chk("reset spi_clk", 32'(sck1), 32'd0);
    chk("reset mosi", 32'(mosi1), 32'd0);
    chk("reset busy", 32'(busy1), 32'd0);
    chk("reset rx_valid", 32'(rxv1), 32'd0);
    chk("reset rx_data", 32'(rxd1), 32'd0);
    chk("reset tx_ready", 32'(rdy1), 32'd0);
    chk("reset ss_n dut2", 32'(ssn2), 32'd1);
    rst_n = 1'b1;
    #1;
    chk("ready after release", 32'(rdy1), 32'd1);

    // mode 0 loopback 0xA5
    eb = edges1;
    send(0, 16'h00A5, 16'h00A5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, acc);
    chk("mode0 ss_n in LEAD", 32'(ssn1), 32'hE);
    wait_idle(0, ic);
    chk("mode0 spi edges", 32'(edges1 - eb), 32'd16);
    chk("mode0 rx_valid cycle", 32'(rx_cyc1 - acc + 1), 32'd35);
    chk("mode0 last ss low cycle", 32'(last_low1 - acc + 1), 32'd36);
    chk("mode0 idle cycle", 32'(ic - acc + 1), 32'd37);
    chk("mode0 mosi bits", 32'(cap1), 32'hA5);
    chk("mode0 ss_n idle", 32'(ssn1), 32'hF);

    // mode 3, slave drives 0x3C, send 0xFF
    loopback = 1'b0;
    slave_word = 8'h3C;
    lead_base = lead1;
    send(0, 16'h00FF, 16'h003C, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, acc);
    chk("mode3 spi_clk in LEAD", 32'(sck1), 32'd1);
    wait_idle(0, ic);
    chk("mode3 spi_clk idle", 32'(sck1), 32'd1);
    chk("mode3 mosi bits", 32'(cap1), 32'hFF);
    loopback = 1'b1;

    // burst 0x11 (hold) then 0x22 on sel 2
    vb = viol1;
    rb = rx_cnt1;
    burst_chk = 1'b1;
    send(0, 16'h0011, 16'h0011, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, acc);
    send(0, 16'h0022, 16'h0022, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, acc2);
    wait_idle(0, ic);
    burst_chk = 1'b0;
    chk("burst ss_n[2] continuous", 32'(viol1 - vb), 32'd0);
    chk("burst rx pulses", 32'(rx_cnt1 - rb), 32'd2);
    chk("burst second accept in HOLD", 32'(acc2 - acc), 32'd35);
    chk("burst ss_n after TRAIL", 32'(ssn1), 32'hF);

    // HOLD on sel 1, then a word for sel 3
    send(0, 16'h005A, 16'h005A, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, acc);
    chk("hold sel1 ss_n", 32'(ssn1), 32'hD);
    send(0, 16'h00C3, 16'h00C3, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, acc2);
    chk("sel change accept after TRAIL", 32'(acc2 - acc), 32'd38);
    chk("sel3 fresh LEAD ss_n", 32'(ssn1), 32'h7);
    wait_idle(0, ic);
    chk("sel3 rx_valid cycle", 32'(rx_cyc1 - acc2 + 1), 32'd35);

    // reset during bit 4 of XFER
    rb = rx_cnt1;
    send(0, 16'h0096, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, acc);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset ss_n", 32'(ssn1), 32'hF);
    chk("midreset spi_clk", 32'(sck1), 32'd0);
    chk("midreset busy", 32'(busy1), 32'd0);
    chk("midreset rx_valid", 32'(rxv1), 32'd0);
    chk("midreset tx_ready", 32'(rdy1), 32'd0);
    chk("midreset rx_data", 32'(rxd1), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready after midreset", 32'(rdy1), 32'd1);
    send(0, 16'h003C, 16'h003C, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, acc);
    wait_idle(0, ic);
    chk("rx pulses across reset", 32'(rx_cnt1 - rb), 32'd1);

    // 16-bit LSB-first, CLK_DIV=1
    send(1, 16'h8001, 16'h8001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, acc);
    chk("lsb first bit in LEAD", 32'(mosi2), 32'd1);
    wait_idle(1, ic);
    chk("lsb rx latency", 32'(rx_cyc2 - acc + 1), 32'd34);
    chk("lsb mosi bits 8001", 32'(cap2), 32'h8001);
    send(1, 16'h0003, 16'h0003, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, acc);
    wait_idle(1, ic);
    chk("lsb mosi bits 0003", 32'(cap2), 32'h0003);

    repeat (4) @(negedge clk);
    chk("scoreboard1 drained", 32'(exp_q1.size()), 32'd0);
    chk("scoreboard2 drained", 32'(exp_q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
